// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory image loader.
// Included by the interface and the loader top.
package imem_loader_pkg;

   localparam int         WORD_W  = 32;
   localparam int         BYTE_W  = 8;
   localparam logic [3:0] WEA_ALL = 4'hF;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_DATA,
      S_CHK,
      S_FIN
   } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input plus instruction-memory port A write bus.
// The loader drives the memory side and consumes the stream (master).
interface imem_loader_if;
   import imem_loader_pkg::*;

   logic              in_valid;
   logic [BYTE_W-1:0] in_data;
   logic              in_ready;
   logic [3:0]        wea;
   logic [WORD_W-1:0] addra;
   logic [WORD_W-1:0] dina;

   modport master (
      input  in_valid, in_data,
      output in_ready, wea, addra, dina
   );

   modport slave (
      output in_valid, in_data,
      input  in_ready, wea, addra, dina
   );

endinterface

// File: rtl/imem_loader.sv
// Loads a little-endian program image (count, words, XOR checksum) into
// instruction memory port A and holds the CPU in reset until a clean load.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter logic [WORD_W-1:0] BASE_ADDR = '0,
   parameter int                DEPTH     = 1024
) (
   input  logic          clka,
   input  logic          rsta,
   input  logic          start,
   imem_loader_if.master bus,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic          cpu_rst
);

   localparam logic [WORD_W-1:0] DEPTH_W = WORD_W'(DEPTH);

   state_t            r_state;
   logic [WORD_W-1:0] r_n;
   logic [WORD_W-1:0] r_idx;
   logic [WORD_W-1:0] r_word;
   logic [1:0]        r_bidx;
   logic [BYTE_W-1:0] r_xor;
   logic              r_in_ready;
   logic [3:0]        r_wea;
   logic [WORD_W-1:0] r_addra;
   logic [WORD_W-1:0] r_dina;
   logic              r_busy;
   logic              r_done;
   logic              r_err;
   logic              r_cpu_rst;

   logic              w_xfer;
   logic [WORD_W-1:0] w_shift;
   logic [BYTE_W-1:0] w_xor;

   assign w_xfer  = bus.in_valid & r_in_ready;
   // Bytes arrive LSB first, so each new byte enters at the top and slides down.
   assign w_shift = {bus.in_data, r_word[WORD_W-1:BYTE_W]};
   assign w_xor   = r_xor ^ bus.in_data;

   always_ff @(posedge clka) begin
      if (rsta) begin
         r_state    <= S_IDLE;
         r_n        <= '0;
         r_idx      <= '0;
         r_word     <= '0;
         r_bidx     <= '0;
         r_xor      <= '0;
         r_in_ready <= 1'b0;
         r_wea      <= '0;
         r_addra    <= '0;
         r_dina     <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_cpu_rst  <= 1'b1;
      end else begin
         r_wea <= '0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_done     <= 1'b0;
                  r_err      <= 1'b0;
                  r_busy     <= 1'b1;
                  r_cpu_rst  <= 1'b1;
                  r_xor      <= '0;
                  r_bidx     <= '0;
                  r_idx      <= '0;
                  r_in_ready <= 1'b1;
                  r_state    <= S_HDR;
               end
            end
            S_HDR: begin
               if (w_xfer) begin
                  r_word <= w_shift;
                  r_xor  <= w_xor;
                  r_bidx <= r_bidx + 2'd1;
                  if (r_bidx == 2'd3) begin
                     r_n <= w_shift;
                     if (w_shift > DEPTH_W) begin
                        // Oversized image: no data is accepted, CPU stays in reset.
                        r_err      <= 1'b1;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_state    <= S_FIN;
                     end else if (w_shift == '0) begin
                        r_state <= S_CHK;
                     end else begin
                        r_state <= S_DATA;
                     end
                  end
               end
            end
            S_DATA: begin
               if (w_xfer) begin
                  r_word <= w_shift;
                  r_xor  <= w_xor;
                  r_bidx <= r_bidx + 2'd1;
                  if (r_bidx == 2'd3) begin
                     r_wea   <= WEA_ALL;
                     r_addra <= BASE_ADDR + r_idx;
                     r_dina  <= w_shift;
                     r_idx   <= r_idx + 1'b1;
                     if (r_idx == r_n - 1'b1)
                        r_state <= S_CHK;
                  end
               end
            end
            S_CHK: begin
               if (w_xfer) begin
                  r_xor      <= w_xor;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b0;
                  r_done     <= 1'b1;
                  r_state    <= S_FIN;
                  if (w_xor != '0)
                     r_err <= 1'b1;
                  else
                     r_cpu_rst <= 1'b0;
               end
            end
            S_FIN: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready = r_in_ready;
   assign bus.wea      = r_wea;
   assign bus.addra    = r_addra;
   assign bus.dina     = r_dina;
   assign busy         = r_busy;
   assign done         = r_done;
   assign err          = r_err;
   assign cpu_rst      = r_cpu_rst;

endmodule

// File: doc/imem_loader.md
# imem_loader

Writes a program image into the instruction memory's write port (`wea`/`addra`/`dina`), the write-side counterpart of the processor's instruction fetch reads. It accepts a little-endian byte stream over a valid/ready handshake, assembles 32-bit words, writes them to consecutive word addresses, verifies an XOR checksum, and holds the processor in reset until a load completes cleanly. It sits between the host-link byte source and the instruction memory, sharing the memory's clock.

## Interface
- `BASE_ADDR`, 0, word address of the first program word
- `DEPTH`, 1024, maximum number of program words accepted
- `clka`  in  1  clock, shared with instruction memory port A
- `rsta`  in  1  reset; one clock; reset is synchronous and active-high
- `start`  in  1  one-cycle pulse that begins a load; ignored while `busy`
- `in_valid`  in  1  byte-stream valid
- `in_data`  in  8  byte-stream data
- `in_ready`  out  1  byte-stream ready
- `wea`  out  4  memory byte-write enables, `4'hF` or `4'h0`
- `addra`  out  32  memory word address
- `dina`  out  32  memory write data
- `busy`  out  1  load in progress
- `done`  out  1  load finished (sticky until next `start` or reset)
- `err`  out  1  load failed (sticky until next `start` or reset)
- `cpu_rst`  out  1  processor reset request

## Operation
- Stream format: 4-byte word count N (LSB first), then N words of 4 bytes each (LSB first), then 1 checksum byte equal to the XOR of all preceding bytes (header and data).
- FSM states: IDLE, HDR, DATA, CHK, FIN.
- IDLE: `in_ready`=0. On `start`, clear `done`/`err`, set `busy`=1 and `cpu_rst`=1, clear the running XOR, then go to HDR.
- HDR: accept 4 bytes into N. After the 4th byte:
  - N > DEPTH: go to FIN with `err`=1.
  - N = 0: go to CHK.
  - Otherwise: go to DATA.
- DATA: accept bytes into a 2-bit byte index and shift them into a word register. On the 4th byte, issue a write and increment the word index. After word N-1 is written, go to CHK.
- CHK: accept 1 byte. If running XOR ^ byte ≠ 0, set `err`=1. Go to FIN.
- FIN: `busy`=0, `done`=1, `in_ready`=0. `cpu_rst`=0 only if `err`=0, otherwise it stays 1. Go to IDLE.
- Running XOR: updated on every accepted byte in HDR, DATA and CHK.
- Address arithmetic: word index is 32-bit unsigned; `addra` = `BASE_ADDR` + index, modulo 2^32.
- `start` while `busy` is ignored.
- `rsta` during a load aborts it. No further writes are issued, and all outputs take their reset values.

## Timing
- Reset values: `in_ready`=0, `wea`=0, `addra`=0, `dina`=0, `busy`=0, `done`=0, `err`=0, `cpu_rst`=1.
- A byte transfers on a rising edge with `in_valid`&`in_ready`.
- `in_ready` is registered: 1 in HDR, DATA and CHK, 0 elsewhere. The block never back-pressures within a load.
- Write latency: `wea`=`4'hF` with valid `addra`/`dina` for exactly one cycle, the cycle after the 4th byte of a word is accepted. Back-to-back words at 1 byte per cycle yield one write every 4 cycles.
- `wea`=0 in every cycle other than a write cycle. `addra`/`dina` hold their last values.
- FIN lasts one cycle. `busy` falls and `done` rises in the same cycle, one cycle after the checksum byte (or the 4th header byte when N>DEPTH).
- `start` is sampled only in IDLE. A `start` in the FIN cycle is dropped.

## Structure
- Shared package `imem_loader_pkg`: state enum, `WORD_W`=32, `BYTE_W`=8, `WEA_ALL`=`4'hF`.
- Single module. No sub-module is needed; the byte-to-word assembler stays inline.

## Test plan
- N=2, words `0x11223344`, `0xAABBCCDD`, correct checksum, BASE_ADDR=0 -> writes at addra 0 and 1 with those words; `done`=1, `err`=0, `cpu_rst`=0; a read-back through port A returns both words.
- N=3, correct data, checksum byte flipped by `0x01` -> all 3 words written; `done`=1, `err`=1, `cpu_rst`=1.
- N=DEPTH+1 -> no write cycles; FIN follows the 4th header byte; `err`=1.
- N=0 followed by checksum `0x00` -> no writes; `done`=1, `err`=0.
- `in_valid` toggling every other cycle with N=1 -> exactly one write (`wea`=`4'hF` for one cycle); `start` pulses issued mid-load have no effect.
- `rsta` asserted after 6 data bytes -> next cycle `wea`=0, `busy`=0, `in_ready`=0, `cpu_rst`=1; a new `start` then loads N=1 correctly at BASE_ADDR.
